// File: rtl/sram_ctrl_if.sv
// Request/response channel between system logic and sram_ctrl.
// The master drives requests; the slave (controller) returns one-cycle completions.
interface sram_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (output req_valid, req_we, req_addr, req_wdata, req_be,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: single read/write accesses with SETUP/PULSE/HOLD timing.
// Define SRAM_WR_VERIFY_EN to follow every write with a read-back compare reported on rsp_err.
module sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 2,
  parameter int T_HOLD  = 1,
  parameter int T_TURN  = 1,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [BE_W-1:0]   SRAM_BE_N
);
  localparam int T_M1  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_M2  = (T_HOLD > T_TURN) ? T_HOLD : T_TURN;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_TURN  = CNT_W'((T_TURN > 0) ? T_TURN - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, TURN
`ifdef SRAM_WR_VERIFY_EN
    , VSETUP, VPULSE, VHOLD
`endif
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              we_r, we_n;
  logic [BE_W-1:0]   be_r, be_n;
  logic [DATA_W-1:0] wdata_r;
  logic              dq_oe;
  logic              accept, done, rd_smp;
  logic              in_acc, in_ver, ver_pulse;

  assign SRAM_DQ       = dq_oe ? wdata_r : {DATA_W{1'bz}};
  assign bus.req_ready = (state == IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
    done    = 1'b0;
    rd_smp  = 1'b0;
    accept  = (state == IDLE) && bus.req_valid;
    // strobes are registered from the next state, so fields must be visible on the accept edge
    we_n    = accept ? bus.req_we : we_r;
    be_n    = accept ? bus.req_be : be_r;
    case (state)
      IDLE:  if (bus.req_valid) begin state_n = SETUP; cnt_n = LD_SETUP; end
      SETUP: if (cnt == '0) begin state_n = PULSE; cnt_n = LD_PULSE; end
      PULSE: if (cnt == '0) begin state_n = HOLD; cnt_n = LD_HOLD; rd_smp = !we_r; end
      HOLD: if (cnt == '0) begin
`ifdef SRAM_WR_VERIFY_EN
        if (we_r) begin
          if (T_TURN > 0) begin state_n = TURN; cnt_n = LD_TURN; end
          else begin state_n = VSETUP; cnt_n = LD_SETUP; end
        end else
`endif
        begin
          done = 1'b1;
          if (!we_r && T_TURN > 0) begin state_n = TURN; cnt_n = LD_TURN; end
          else state_n = IDLE;
        end
      end
      TURN: if (cnt == '0) begin
`ifdef SRAM_WR_VERIFY_EN
        if (we_r) begin state_n = VSETUP; cnt_n = LD_SETUP; end else
`endif
        state_n = IDLE;
      end
`ifdef SRAM_WR_VERIFY_EN
      VSETUP: if (cnt == '0) begin state_n = VPULSE; cnt_n = LD_PULSE; end
      VPULSE: if (cnt == '0) begin state_n = VHOLD; cnt_n = LD_HOLD; end
      VHOLD:  if (cnt == '0) begin state_n = IDLE; done = 1'b1; end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign in_acc = (state_n == SETUP) || (state_n == PULSE) || (state_n == HOLD);
`ifdef SRAM_WR_VERIFY_EN
  assign in_ver    = (state_n == VSETUP) || (state_n == VPULSE) || (state_n == VHOLD);
  assign ver_pulse = (state_n == VPULSE);
`else
  assign in_ver    = 1'b0;
  assign ver_pulse = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      we_r          <= 1'b0;
      be_r          <= '0;
      wdata_r       <= '0;
      dq_oe         <= 1'b0;
      SRAM_ADDR     <= '0;
      SRAM_CE_N     <= 1'b1;
      SRAM_OE_N     <= 1'b1;
      SRAM_WE_N     <= 1'b1;
      SRAM_BE_N     <= '1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        we_r      <= bus.req_we;
        be_r      <= bus.req_be;
        wdata_r   <= bus.req_wdata;
        SRAM_ADDR <= bus.req_addr;
      end
      SRAM_CE_N     <= !(in_acc || in_ver);
      SRAM_WE_N     <= !((state_n == PULSE) && we_n);
      SRAM_OE_N     <= !(((state_n == PULSE) && !we_n) || ver_pulse);
      SRAM_BE_N     <= in_acc ? (we_n ? ~be_n : '0) : (in_ver ? '0 : '1);
      dq_oe         <= in_acc && we_n;
      bus.rsp_valid <= done;
      if (rd_smp) bus.rsp_rdata <= SRAM_DQ;
    end
  end

`ifdef SRAM_WR_VERIFY_EN
  logic [DATA_W-1:0] be_mask;
  logic              v_smp, vfail;

  for (genvar b = 0; b < BE_W; b++) begin : g_mask
    assign be_mask[b*8 +: 8] = {8{be_r[b]}};
  end

  assign v_smp = (state == VPULSE) && (cnt == '0);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vfail       <= 1'b0;
      bus.rsp_err <= 1'b0;
    end else begin
      if (v_smp) vfail <= |((SRAM_DQ ^ wdata_r) & be_mask);
      // a read completion must not inherit a stale verify result
      bus.rsp_err <= done && we_r && vfail;
    end
  end
`else
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) bus.rsp_err <= 1'b0;
    else         bus.rsp_err <= 1'b0;
  end
`endif
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised asynchronous-SRAM controller; successor to the fixed 16-bit, free-running write/read test sequencer.
- Accepts single read/write requests over a valid/ready interface and generates CE/OE/WE/byte-lane strobes with per-phase timing set by parameters.
- Returns read data or write completion on a one-cycle response strobe.
- Sits between system logic (test engines, DMA, CPU bridge) and the board SRAM pins.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width; must be a multiple of 8; BE_W = DATA_W/8.
- T_SETUP, 1, cycles address/CE/BE are valid before the WE/OE pulse (>=1).
- T_PULSE, 2, cycles WE_N or OE_N held low (>=1).
- T_HOLD, 1, cycles address/data/CE held after the pulse ends (>=1).
- T_TURN, 1, idle cycles forced after a read before a write may start (>=0).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  write byte enables, active-high.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_W  read data, valid while rsp_valid is high on a read.
- rsp_err  out  1  write-verify mismatch (see Optional Feature).
- SRAM_ADDR  out  ADDR_W  SRAM address, registered.
- SRAM_DQ  inout  DATA_W  SRAM data bus.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low strobes, registered.
- SRAM_BE_N  out  BE_W  active-low byte-lane enables, registered; bit 0 = LB, bit 1 = UB.

Behaviour:
- Reset (asynchronous, immediate, including mid-cycle):
  - State IDLE; SRAM_CE_N, SRAM_OE_N, SRAM_WE_N = 1; SRAM_BE_N all 1; SRAM_ADDR = 0.
  - SRAM_DQ released (Z); req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - Any in-flight access is abandoned, with no response.
- FSM states: IDLE, SETUP, PULSE, HOLD, TURN (plus VSETUP, VPULSE, VHOLD when the optional feature is compiled in).
- One down-counter, width $clog2 of the largest timing parameter + 1, is loaded on each phase entry.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on the edge where req_valid && req_ready. Request fields are registered at that edge; they may change afterwards.
- Accept edge (cycle 0):
  - IDLE -> SETUP.
  - SRAM_ADDR = req_addr and SRAM_CE_N = 0 from cycle 1.
  - Write: SRAM_BE_N = ~req_be.
  - Read: SRAM_BE_N = all 0; req_be is ignored.
- SETUP: T_SETUP cycles.
  - Write: SRAM_DQ driven with the write data.
  - Then -> PULSE.
- PULSE: T_PULSE cycles with SRAM_WE_N = 0 (write) or SRAM_OE_N = 0 (read).
  - On a read, SRAM_DQ is sampled into rsp_rdata at the last PULSE edge.
  - Then -> HOLD.
- HOLD: T_HOLD cycles.
  - WE_N and OE_N = 1; CE_N, BE_N and address held.
  - Write data still driven.
- HOLD exit:
  - CE_N and BE_N return to 1.
  - SRAM_DQ released.
  - rsp_valid = 1 for exactly one cycle (cycle T_SETUP+T_PULSE+T_HOLD+1 after accept).
- Next state after HOLD:
  - After a read with T_TURN > 0: -> TURN for T_TURN cycles with req_ready = 0, then -> IDLE.
  - Otherwise: -> IDLE; req_ready = 1 in the same cycle as rsp_valid.
- rsp_rdata holds its value until the next read completes; writes leave it unchanged.
- SRAM_DQ is driven only from SETUP through HOLD of a write; it is never driven in IDLE, TURN or any read phase.
- A write with req_be == 0 runs full timing with SRAM_BE_N all 1 (no-op) and still completes with rsp_valid.
- There is no response backpressure; the requester must accept rsp_valid.
- The SRAM_ADDR register retains its last value in IDLE.

Optional Feature:
- Macro: SRAM_WR_VERIFY_EN.
- Defined:
  - After write HOLD, the FSM runs TURN (T_TURN cycles), then VSETUP, VPULSE and VHOLD as a read of the same address (BE_N all 0).
  - The VPULSE sample is compared with the written data on enabled bytes only.
  - rsp_valid is issued after VHOLD, giving write latency 2*(T_SETUP+T_PULSE+T_HOLD)+T_TURN+1.
  - rsp_err = 1 with rsp_valid on a mismatch, else 0.
  - rsp_err is 0 whenever rsp_valid is 0.
  - rsp_rdata is not updated by the verify read.
- Undefined: verify states are absent; rsp_err is tied to 0; latencies are as in Behaviour.

Test Plan:
- Defaults. Write addr 0x00012, data 0x5555, be 2'b11, accepted at cycle 0 -> cycle 1: CE_N = 0, BE_N = 00, DQ = 0x5555, WE_N = 1; cycles 2-3: WE_N = 0; cycle 4: WE_N = 1, DQ still driven; cycle 5: rsp_valid = 1, DQ = Z, req_ready = 1.
- Read addr 0x00012 with the SRAM model returning 0x5555 -> OE_N = 0 on cycles 2-3; rsp_valid at cycle 5 with rsp_rdata = 0x5555; req_ready low at cycle 5, high at cycle 6 (T_TURN = 1).
- Write be = 2'b10, data 0xA5C3 over stored 0x5555, then read -> BE_N = 01 during the write; read returns 0xA555.
- Read immediately followed by a pending write -> write accepted no earlier than cycle 6; DQ is never driven by both the controller and the SRAM model in any cycle.
- sys_rst asserted during the write PULSE -> same cycle: WE_N = 1, CE_N = 1, DQ = Z; no rsp_valid; after release, req_ready = 1.
- SRAM_WR_VERIFY_EN defined; SRAM model forced to corrupt bit 0 on writes -> single rsp_valid at cycle 10 with rsp_err = 1; with no corruption, rsp_err = 0.
